// File: rtl/a51_pkg.sv
// A5/1 keystream generator: shared register geometry and state encoding.
//
// Purpose: single home for the LFSR lengths, clocking-bit positions, feedback
// tap masks, load-phase lengths and the controller state type, so the
// register bank and the controller agree on them.
// Ports: none (package).
package a51_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  // Feedback taps: R1 {13,16,17,18}, R2 {20,21}, R3 {7,20,21,22}
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

  localparam int KEY_BITS   = 64;
  localparam int FRAME_BITS = 22;
  localparam int BURST_BITS = 114;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    FRAME,
    MIX,
    OUT
  } a51_state_e;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_lfsr_bank.sv
// A5/1 register bank: R1/R2/R3 with their feedback and stepping rules.
//
// Purpose: holds the three LFSRs and applies one of three per-cycle actions:
// clear to zero, unconditional step with an injected load bit, or
// majority-clocked step.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clear        zero all three registers this edge (highest priority)
//   load_bit     bit XORed into every feedback during a forced step
//   force_step   step all three registers, injecting load_bit
//   step_en      majority-clocked step, no injection
//   out_bit      keystream bit as it will read once this cycle's step is
//                taken; the controller registers it on the stepping edge
module a51_lfsr_bank
  import a51_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load_bit,
  input  logic force_step,
  input  logic step_en,
  output logic out_bit
);

  logic [R1_LEN-1:0] r1, r1_nxt;
  logic [R2_LEN-1:0] r2, r2_nxt;
  logic [R3_LEN-1:0] r3, r3_nxt;
  logic              maj;
  logic              inj;
  logic              en1, en2, en3;

  always_comb begin
    maj = majority(r1[R1_CLK], r2[R2_CLK], r3[R3_CLK]);
    inj = force_step & load_bit;
    // A register joins the majority step only when its clocking bit agrees
    // with the majority, so at least two of the three move every cycle.
    en1 = force_step | (step_en & (r1[R1_CLK] == maj));
    en2 = force_step | (step_en & (r2[R2_CLK] == maj));
    en3 = force_step | (step_en & (r3[R3_CLK] == maj));
    r1_nxt = en1 ? {r1[R1_LEN-2:0], (^(r1 & R1_TAPS)) ^ inj} : r1;
    r2_nxt = en2 ? {r2[R2_LEN-2:0], (^(r2 & R2_TAPS)) ^ inj} : r2;
    r3_nxt = en3 ? {r3[R3_LEN-2:0], (^(r3 & R3_TAPS)) ^ inj} : r3;
    // Output is taken from the post-step state.
    out_bit = r1_nxt[R1_LEN-1] ^ r2_nxt[R2_LEN-1] ^ r3_nxt[R3_LEN-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else if (clear) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      r1 <= r1_nxt;
      r2 <= r2_nxt;
      r3 <= r3_nxt;
    end
  end

endmodule

// File: rtl/a51_keystream_gen.sv
// A5/1 keystream generator top: load, mix and stream controller.
//
// Purpose: on an accepted start, latches Kc and the frame number, shifts them
// into the register bank (key then frame), runs MIX_CYCLES discarded
// majority cycles, then streams KS_BITS keystream bits (downlink half first,
// then uplink half) over a valid/ready one-bit interface at up to one bit
// per cycle.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   start_i      one-cycle start pulse, only honoured while idle
//   key_i        64-bit Kc, bit 0 loaded first
//   frame_i      22-bit frame number, bit 0 loaded first
//   busy_o       high from the edge that accepts start until the final transfer
//   ks_valid_o   ks_bit_o/ks_last_o/ks_dir_o carry a keystream bit
//   ks_ready_i   downstream accepts the presented bit
//   ks_bit_o     keystream bit
//   ks_last_o    marks the final bit of the frame
//   ks_dir_o     0 for the downlink half, 1 for the uplink half
module a51_keystream_gen
  import a51_pkg::*;
#(
  parameter int MIX_CYCLES = 100,
  parameter int KS_BITS    = 228
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [63:0] key_i,
  input  logic [21:0] frame_i,
  output logic        busy_o,
  output logic        ks_valid_o,
  input  logic        ks_ready_i,
  output logic        ks_bit_o,
  output logic        ks_last_o,
  output logic        ks_dir_o
);

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_BITS - 1);
  localparam logic [CNT_W-1:0] DIR_FIRST  = CNT_W'(BURST_BITS);

  a51_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [63:0]      key_sr;
  logic [21:0]      frame_sr;

  logic lfsr_clear;
  logic force_step;
  logic step_en;
  logic load_bit;
  logic accept;
  logic produce;
  logic finish;
  logic ks_next;

  a51_lfsr_bank u_bank (
    .clk        (clk),
    .reset      (reset),
    .clear      (lfsr_clear),
    .load_bit   (load_bit),
    .force_step (force_step),
    .step_en    (step_en),
    .out_bit    (ks_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // In OUT, cnt is the index of the bit being presented. A bit is produced
  // either on entry (nothing presented yet) or on the same edge that the
  // presented bit transfers, which keeps the stream at one bit per cycle.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    lfsr_clear = 1'b0;
    force_step = 1'b0;
    step_en    = 1'b0;
    accept     = 1'b0;
    produce    = 1'b0;
    finish     = 1'b0;
    load_bit   = (state == FRAME) ? frame_sr[0] : key_sr[0];
    case (state)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          lfsr_clear = 1'b1;
          cnt_d      = '0;
          state_d    = KEY;
        end
      end
      KEY: begin
        force_step = 1'b1;
        if (cnt == KEY_LAST) begin
          cnt_d   = '0;
          state_d = FRAME;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      FRAME: begin
        force_step = 1'b1;
        if (cnt == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = MIX;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      MIX: begin
        step_en = 1'b1;
        if (cnt == MIX_LAST) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      OUT: begin
        if (!ks_valid_o) begin
          produce = 1'b1;
        end else if (ks_ready_i) begin
          if (cnt == KS_LAST) begin
            finish  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            produce = 1'b1;
            cnt_d   = cnt + CNT_W'(1);
          end
        end
        step_en = produce;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      key_sr     <= '0;
      frame_sr   <= '0;
      busy_o     <= 1'b0;
      ks_valid_o <= 1'b0;
      ks_bit_o   <= 1'b0;
      ks_last_o  <= 1'b0;
      ks_dir_o   <= 1'b0;
    end else begin
      cnt <= cnt_d;
      // Key and frame are consumed LSB-first by shifting them down.
      if (accept) begin
        key_sr   <= key_i;
        frame_sr <= frame_i;
        busy_o   <= 1'b1;
      end else begin
        if (state == KEY)   key_sr   <= key_sr >> 1;
        if (state == FRAME) frame_sr <= frame_sr >> 1;
      end
      if (produce) begin
        ks_valid_o <= 1'b1;
        ks_bit_o   <= ks_next;
        ks_last_o  <= (cnt_d == KS_LAST);
        ks_dir_o   <= (cnt_d >= DIR_FIRST);
      end else if (finish) begin
        ks_valid_o <= 1'b0;
        busy_o     <= 1'b0;
        ks_last_o  <= 1'b0;
        ks_dir_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_a51_keystream_gen.sv
// Testbench for a51_keystream_gen: table of frames, each with its expected
// 228-bit keystream, driven through the valid/ready interface while a
// scoreboard queue supplies the expected bit, last and direction flags.
module tb_a51_keystream_gen;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [63:0] key_i;
  logic [21:0] frame_i;
  logic        busy_o;
  logic        ks_valid_o;
  logic        ks_ready_i;
  logic        ks_bit_o;
  logic        ks_last_o;
  logic        ks_dir_o;

  a51_keystream_gen #(.MIX_CYCLES(100), .KS_BITS(228)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .key_i      (key_i),
    .frame_i    (frame_i),
    .busy_o     (busy_o),
    .ks_valid_o (ks_valid_o),
    .ks_ready_i (ks_ready_i),
    .ks_bit_o   (ks_bit_o),
    .ks_last_o  (ks_last_o),
    .ks_dir_o   (ks_dir_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
    logic dir;
  } exp_t;

  typedef struct {
    logic [63:0]  key;
    logic [21:0]  frame;
    int           ready_pct;
    int           spur_k;        // cycle (after accept) of a spurious start, -1 none
    int           reset_bit;     // assert reset while this bit is presented, -1 none
    bit           start_on_last; // pulse start during the final transfer
    bit           chk_timing;
    logic [227:0] exp;
  } vec_t;

  localparam logic [63:0] STD_KEY = 64'hEFCDAB8967452312;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference algorithm in the style of the published C implementation.
  function automatic logic [31:0] clk_one(input logic [31:0] r, input logic [31:0] mask,
                                          input logic [31:0] taps);
    return ((r << 1) & mask) | {31'b0, ^(r & taps)};
  endfunction

  function automatic logic [227:0] a51_model(input logic [63:0] k, input logic [21:0] f);
    logic [31:0]  r1, r2, r3;
    logic         b, c1, c2, c3, m;
    logic [227:0] o;
    r1 = 0; r2 = 0; r3 = 0; o = '0;
    for (int i = 0; i < 86; i++) begin
      b  = (i < 64) ? k[i] : f[i-64];
      r1 = clk_one(r1, 32'h07FFFF, 32'h072000) ^ {31'b0, b};
      r2 = clk_one(r2, 32'h3FFFFF, 32'h300000) ^ {31'b0, b};
      r3 = clk_one(r3, 32'h7FFFFF, 32'h700080) ^ {31'b0, b};
    end
    for (int i = 0; i < 328; i++) begin
      c1 = (r1 & 32'h000100) != 0;
      c2 = (r2 & 32'h000400) != 0;
      c3 = (r3 & 32'h000400) != 0;
      m  = (c1 & c2) | (c1 & c3) | (c2 & c3);
      if (c1 == m) r1 = clk_one(r1, 32'h07FFFF, 32'h072000);
      if (c2 == m) r2 = clk_one(r2, 32'h3FFFFF, 32'h300000);
      if (c3 == m) r3 = clk_one(r3, 32'h7FFFFF, 32'h700080);
      if (i >= 100) o[i-100] = (^(r1 & 32'h040000)) ^ (^(r2 & 32'h200000)) ^ (^(r3 & 32'h400000));
    end
    return o;
  endfunction

  function automatic vec_t mk(input logic [63:0] key, input logic [21:0] frame, input int rp,
                              input int spur, input int rbit, input bit sol, input bit tim,
                              input logic [227:0] exp);
    vec_t v;
    v.key = key; v.frame = frame; v.ready_pct = rp; v.spur_k = spur;
    v.reset_bit = rbit; v.start_on_last = sol; v.chk_timing = tim; v.exp = exp;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int         k, first_valid, n_xfer, busy_bad, stall_bad, stalls;
    logic       held;
    logic [2:0] held_val;
    exp_t       e;
    bit         done, cut;
    sbq.delete();
    for (int i = 0; i < 228; i++) begin
      e.b = v.exp[i]; e.last = (i == 227); e.dir = (i >= 114);
      sbq.push_back(e);
    end
    key_i = v.key; frame_i = v.frame; start_i = 1'b1; ks_ready_i = 1'b0;
    tick();  // accepting edge: k = 0
    start_i = 1'b0; key_i = ~v.key; frame_i = ~v.frame;
    k = 0; first_valid = -1; n_xfer = 0; busy_bad = 0; stall_bad = 0; stalls = 0;
    held = 1'b0; held_val = '0; done = 0; cut = 0;
    while (!done && !cut && k < 3000) begin
      if (busy_o !== 1'b1) busy_bad++;
      if (ks_valid_o === 1'b1 && first_valid < 0) first_valid = k;
      if (held && (ks_valid_o !== 1'b1 || {ks_bit_o, ks_last_o, ks_dir_o} !== held_val)) stall_bad++;
      start_i = (k == v.spur_k);
      if (start_i) begin key_i = 64'hDEADBEEF00C0FFEE; frame_i = 22'h2AAAAA; end
      if (v.reset_bit >= 0 && n_xfer == v.reset_bit && ks_valid_o === 1'b1) begin
        reset = 1'b1;
        #1;
        check($sformatf("v%0d_rst_outs", id), {59'b0, busy_o, ks_valid_o, ks_bit_o, ks_last_o, ks_dir_o}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check($sformatf("v%0d_rst_idle", id), {62'b0, busy_o, ks_valid_o}, 64'd0);
        sbq.delete();
        cut = 1;
      end else begin
        ks_ready_i = (int'($urandom_range(0, 99)) < v.ready_pct);
        if (ks_valid_o === 1'b1 && ks_ready_i) begin
          if (sbq.size() == 0) begin
            check($sformatf("v%0d_extra_bit", id), 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            check($sformatf("v%0d_bit%0d", id, n_xfer), {61'b0, ks_bit_o, ks_last_o, ks_dir_o},
                  {61'b0, e.b, e.last, e.dir});
          end
          if (ks_last_o === 1'b1) begin
            done = 1;
            if (v.start_on_last) begin start_i = 1'b1; key_i = 64'hFFFF0000FFFF0000; end
          end
          n_xfer++;
          held = 1'b0;
        end else if (ks_valid_o === 1'b1) begin
          held = 1'b1;
          held_val = {ks_bit_o, ks_last_o, ks_dir_o};
          stalls++;
        end else begin
          held = 1'b0;
        end
        tick();
        k++;
      end
    end
    if (!cut) begin
      ks_ready_i = 1'b0;
      start_i = 1'b0;
      check($sformatf("v%0d_done", id), {63'b0, done}, 64'd1);
      check($sformatf("v%0d_idle_after", id), {62'b0, busy_o, ks_valid_o}, 64'd0);
      check($sformatf("v%0d_nxfer", id), n_xfer, 228);
      check($sformatf("v%0d_sb_left", id), sbq.size(), 0);
      check($sformatf("v%0d_busy_held", id), busy_bad, 0);
      check($sformatf("v%0d_stall_stable", id), stall_bad, 0);
      if (v.ready_pct < 100) check($sformatf("v%0d_stalls_seen", id), {63'b0, stalls > 0}, 64'd1);
      if (v.chk_timing) begin
        check($sformatf("v%0d_first_valid", id), first_valid, 187);
        check($sformatf("v%0d_busy_fall", id), k, 415);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [115:0] dl, ul;
    logic [227:0] ref_bits, m134, m135, mff;
    vec_t         vecs[7];
    dl = 116'h534EAA582FE8151AB6E1855A728C0;
    ul = 116'h24FD35A35D5FB6526D32F906DF1AC;
    for (int i = 0; i < 114; i++) begin
      ref_bits[i]       = dl[115-i];
      ref_bits[114 + i] = ul[115-i];
    end
    m134 = a51_model(STD_KEY, 22'h134);
    m135 = a51_model(STD_KEY, 22'h135);
    mff  = a51_model(64'h0123456789ABCDEF, 22'h3FFFFF);

    vecs[0] = mk(STD_KEY, 22'h134, 100, -1, -1, 0, 1, ref_bits);
    vecs[1] = mk(STD_KEY, 22'h134, 30, -1, -1, 0, 0, ref_bits);
    vecs[2] = mk(STD_KEY, 22'h134, 100, 50, -1, 0, 1, ref_bits);
    vecs[3] = mk(STD_KEY, 22'h134, 100, -1, 60, 0, 0, ref_bits);
    vecs[4] = mk(STD_KEY, 22'h134, 100, -1, -1, 1, 1, ref_bits);
    vecs[5] = mk(STD_KEY, 22'h135, 100, -1, -1, 0, 1, m135);
    vecs[6] = mk(64'h0123456789ABCDEF, 22'h3FFFFF, 50, -1, -1, 0, 0, mff);

    reset = 1'b1; start_i = 1'b0; key_i = '0; frame_i = '0; ks_ready_i = 1'b0;
    tick();
    tick();
    check("rst_busy",  {63'b0, busy_o},     64'd0);
    check("rst_valid", {63'b0, ks_valid_o}, 64'd0);
    check("rst_bit",   {63'b0, ks_bit_o},   64'd0);
    check("rst_last",  {63'b0, ks_last_o},  64'd0);
    check("rst_dir",   {63'b0, ks_dir_o},   64'd0);
    reset = 1'b0;
    tick();
    check("idle_no_start", {62'b0, busy_o, ks_valid_o}, 64'd0);
    check("model_vs_ref", {63'b0, m134 == ref_bits}, 64'd1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
